// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing.
// Outputs decode from the current state (plus mem_ack/zero gating); memory waits trap after MEM_TIMEOUT cycles.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ack,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic [2:0] alu_op,
  output logic [3:0] state_o,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,  FETCH    = 4'd1,  DECODE   = 4'd2,  EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,  MEM_ADDR = 4'd5,  MEM_RD   = 4'd6,  MEM_WR   = 4'd7,
    WB_R     = 4'd8,  WB_I     = 4'd9,  WB_MEM   = 4'd10, BRANCH   = 4'd11,
    JUMP     = 4'd12, TRAP     = 4'd13
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       wait_st;
  logic       to_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign wait_st = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  // An ack on the last allowed cycle takes priority over the trap.
  assign to_hit  = (cnt_q == TO_LAST) && !mem_ack;

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    alu_op     = 3'b100;
    instr_done = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
        if (mem_ack)     state_d = DECODE;
        else if (to_hit) state_d = TRAP;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          6'b000000:                                  state_d = EXEC_R;
          6'b001000, 6'b001100, 6'b001101, 6'b001111: state_d = EXEC_I;
          6'b100011, 6'b101011:                       state_d = MEM_ADDR;
          6'b000100, 6'b000101:                       state_d = BRANCH;
          6'b000010:                                  state_d = JUMP;
          default:                                    state_d = TRAP;
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b111;
        state_d   = WB_R;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          6'b001100: alu_op = 3'b110;
          6'b001101: alu_op = 3'b101;
          6'b001111: alu_op = 3'b000;
          default:   alu_op = 3'b100;
        endcase
        state_d = WB_I;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == 6'b101011) ? 3'b011 : 3'b010;
        state_d   = (opcode == 6'b101011) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ack)     state_d = WB_MEM;
        else if (to_hit) state_d = TRAP;
      end
      MEM_WR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ack;
        if (mem_ack)     state_d = FETCH;
        else if (to_hit) state_d = TRAP;
      end
      WB_R: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      WB_I: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b001;
        pc_source  = 2'b01;
        pc_write   = (opcode == 6'b000101) ? !zero : zero;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)
      cnt_d = 8'd0;
    else if (wait_st && !mem_ack)
      cnt_d = 8'(cnt_q + 8'd1);
  end

  assign illegal_d = illegal_q || ((state_q == DECODE) && (state_d == TRAP));
  assign timeout_d = timeout_q || (wait_st && (state_d == TRAP));

  assign state_o     = state_q;
  assign illegal_op  = illegal_q;
  assign mem_timeout = timeout_q;

endmodule
